// File: rtl/mux5_8a_pkg.sv
// Shared constants and types for the registered 5-to-1 byte selector.
package mux5_8a_pkg;

    localparam int WIDTH = 8;
    localparam int N_IN  = 5;
    localparam int SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_MAX = 3'd4;

    typedef logic [WIDTH-1:0] data_t;

endpackage

// File: rtl/mux5_8a_comb.sv
// Combinational 5-to-1 pick; unknown or out-of-range codes yield zero and raise err.
module mux5_8a_comb
    import mux5_8a_pkg::*;
#(
    parameter int DW = mux5_8a_pkg::WIDTH
) (
    input  logic [DW-1:0]    in0,
    input  logic [DW-1:0]    in1,
    input  logic [DW-1:0]    in2,
    input  logic [DW-1:0]    in3,
    input  logic [DW-1:0]    in4,
    input  logic [SEL_W-1:0] sel,
    output logic [DW-1:0]    pick,
    output logic             err
);

    // Codes with X/Z bits match no label and fall into the default branch.
    always_comb begin
        pick = '0;
        err  = 1'b0;
        case (sel)
            3'd0:    pick = in0;
            3'd1:    pick = in1;
            3'd2:    pick = in2;
            3'd3:    pick = in3;
            3'd4:    pick = in4;
            default: err  = 1'b1;
        endcase
    end

endmodule

// File: rtl/mux5_8a_reg.sv
// Registered 5-to-1 selector: one-cycle latency, enable hold, synchronous reset.
module mux5_8a_reg #(
    parameter int WIDTH = mux5_8a_pkg::WIDTH,
    parameter int N_IN  = mux5_8a_pkg::N_IN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] out,
    output logic             sel_err
);

    import mux5_8a_pkg::*;

    logic [WIDTH-1:0] pick;
    logic             err;

    mux5_8a_comb #(
        .DW (WIDTH)
    ) u_comb (
        .in0  (in0),
        .in1  (in1),
        .in2  (in2),
        .in3  (in3),
        .in4  (in4),
        .sel  (sel),
        .pick (pick),
        .err  (err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out     <= '0;
            sel_err <= 1'b0;
        end else if (en) begin
            out     <= pick;
            sel_err <= err;
        end
    end

`ifndef SYNTHESIS
    initial begin
        assert (N_IN == 5 && SEL_MAX == 3'(N_IN - 1))
            else $error("mux5_8a_reg: block is built for exactly five inputs");
    end

    a_err_zero: assert property (@(posedge clk) sel_err |-> (out == '0));

    // A reset edge may clear out even while en is low, so it is excluded.
    a_hold: assert property (@(posedge clk) disable iff (rst)
        (!$past(en) && !$past(rst)) |-> $stable(out));
`endif

endmodule

// File: tb/tb_mux5_8a_reg.sv
// Directed self-checking bench for mux5_8a_reg.
module tb_mux5_8a_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] in0, in1, in2, in3, in4;
    logic [2:0] sel;
    logic [7:0] out;
    logic       sel_err;

    int n_checks = 0;
    int n_fail   = 0;

    mux5_8a_reg dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .in0     (in0),
        .in1     (in1),
        .in2     (in2),
        .in3     (in3),
        .in4     (in4),
        .sel     (sel),
        .out     (out),
        .sel_err (sel_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] exp_out, input logic exp_err);
        n_checks++;
        assert (out === exp_out) else begin
            n_fail++;
            $error("FAIL %s out: got %h expected %h", tag, out, exp_out);
        end
        n_checks++;
        assert (sel_err === exp_err) else begin
            n_fail++;
            $error("FAIL %s sel_err: got %b expected %b", tag, sel_err, exp_err);
        end
    endtask

    logic [7:0] sweep_out [8];
    logic       sweep_err [8];

    initial begin
        sweep_out = '{8'd2, 8'd4, 8'd8, 8'd16, 8'd32, 8'd0, 8'd0, 8'd0};
        sweep_err = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        rst = 1'b1; en = 1'b0; sel = 3'd0;
        in0 = 8'd2; in1 = 8'd4; in2 = 8'd8; in3 = 8'd16; in4 = 8'd32;
        tick();
        check("reset_init", 8'h00, 1'b0);

        rst = 1'b0; en = 1'b1;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            tick();
            check($sformatf("sweep_sel%0d", s), sweep_out[s], sweep_err[s]);
        end

        // Reset clears a pending error and a loaded value
        sel = 3'd5; tick();
        check("err_before_rst", 8'h00, 1'b1);
        sel = 3'd3; tick();
        check("load16", 8'd16, 1'b0);
        sel = 3'd6; tick();
        rst = 1'b1; tick();
        check("rst_edge1", 8'h00, 1'b0);
        tick();
        check("rst_edge2", 8'h00, 1'b0);
        rst = 1'b0; sel = 3'd1; tick();
        check("rst_release", 8'd4, 1'b0);

        rst = 1'b1; en = 1'b1; sel = 3'd4; tick();
        check("rst_over_en", 8'h00, 1'b0);
        rst = 1'b0;

        sel = 3'd2; tick();
        check("hold_load", 8'd8, 1'b0);
        en = 1'b0; sel = 3'd4; in2 = 8'd99;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("hold_c%0d", k), 8'd8, 1'b0);
        end
        en = 1'b1; tick();
        check("hold_release", 8'd32, 1'b0);

        sel = 3'd3;
        in3 = 8'h00; tick(); check("track_00", 8'h00, 1'b0);
        in3 = 8'hFF; tick(); check("track_FF", 8'hFF, 1'b0);
        in3 = 8'hA5; tick(); check("track_A5", 8'hA5, 1'b0);

        in0 = 8'h5A;
        sel = 3'd7; tick(); check("recover_err", 8'h00, 1'b1);
        sel = 3'd0; tick(); check("recover_ok", 8'h5A, 1'b0);

        // Error flag also freezes while disabled
        sel = 3'd6; tick(); check("err_set", 8'h00, 1'b1);
        en = 1'b0; sel = 3'd0; tick(); check("err_frozen", 8'h00, 1'b1);
        en = 1'b1; tick(); check("err_unfrozen", 8'h5A, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
